// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use stall, bubble insertion and IF flush.
// Ports: clk_i/rst_i (async active-low); ConMux_i {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp,RegDst},
// Branch_taken_i/Jump_i and ID operands/addresses in; registered EX_* fields out; PCWrite_o/IFIDWrite_o
// hold PC and IF/ID on a stall; IFFlush_o clears IF/ID on a taken branch or jump.
// Define HAZARD_STAT_EN to add saturating StallCnt_o/FlushCnt_o counters (width CNT_W).
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
`ifdef HAZARD_STAT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        ConMux_i,
  input  logic              Branch_taken_i,
  input  logic              Jump_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [REG_AW-1:0] RSaddr_i,
  input  logic [REG_AW-1:0] RTaddr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic [1:0]        EX_WB_o,
  output logic [1:0]        EX_M_o,
  output logic              EX_ALUSrc_o,
  output logic [1:0]        EX_ALUOp_o,
  output logic              EX_RegDst_o,
  output logic [DATA_W-1:0] EX_RSdata_o,
  output logic [DATA_W-1:0] EX_RTdata_o,
  output logic [DATA_W-1:0] EX_Imm_o,
  output logic [REG_AW-1:0] EX_RSaddr_o,
  output logic [REG_AW-1:0] EX_RTaddr_o,
  output logic [REG_AW-1:0] EX_RDaddr_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
`ifdef HAZARD_STAT_EN
  output logic [CNT_W-1:0]  StallCnt_o,
  output logic [CNT_W-1:0]  FlushCnt_o,
`endif
  output logic              IFFlush_o
);
  logic [7:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rsd_q, rtd_q, imm_q;
  logic [REG_AW-1:0] rsa_q, rta_q, rda_q;
  logic              stall;
  // A load in EX whose destination feeds the instruction in ID; a load to $zero never hazards.
  assign stall = ctrl_q[5] & (|rta_q) & ((rta_q == RSaddr_i) | (rta_q == RTaddr_i));
  assign ctrl_d = stall ? 8'h00 : ConMux_i;
  assign PCWrite_o   = ~stall;
  assign IFIDWrite_o = ~stall;
  // Stall wins: the branch/jump waits in ID and is re-evaluated next cycle.
  assign IFFlush_o = rst_i & (Branch_taken_i | Jump_i) & ~stall;
  assign EX_WB_o     = ctrl_q[7:6];
  assign EX_M_o      = ctrl_q[5:4];
  assign EX_ALUSrc_o = ctrl_q[3];
  assign EX_ALUOp_o  = ctrl_q[2:1];
  assign EX_RegDst_o = ctrl_q[0];
  assign EX_RSdata_o = rsd_q;
  assign EX_RTdata_o = rtd_q;
  assign EX_Imm_o    = imm_q;
  assign EX_RSaddr_o = rsa_q;
  assign EX_RTaddr_o = rta_q;
  assign EX_RDaddr_o = rda_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      ctrl_q <= '0;
      rsd_q  <= '0;
      rtd_q  <= '0;
      imm_q  <= '0;
      rsa_q  <= '0;
      rta_q  <= '0;
      rda_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rsd_q  <= RSdata_i;
      rtd_q  <= RTdata_i;
      imm_q  <= Imm_i;
      rsa_q  <= RSaddr_i;
      rta_q  <= RTaddr_i;
      rda_q  <= RDaddr_i;
    end
`ifdef HAZARD_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  assign stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign flush_cnt_d = (IFFlush_o & ~&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
`endif
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_id_ex_hazard_reg;
`ifdef HAZARD_STAT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  ConMux_i = '0;
  logic        Branch_taken_i = 1'b0, Jump_i = 1'b0;
  logic [31:0] RSdata_i = '0, RTdata_i = '0, Imm_i = '0;
  logic [4:0]  RSaddr_i = '0, RTaddr_i = '0, RDaddr_i = '0;
  logic [1:0]  EX_WB_o, EX_M_o, EX_ALUOp_o;
  logic        EX_ALUSrc_o, EX_RegDst_o, PCWrite_o, IFIDWrite_o, IFFlush_o;
  logic [31:0] EX_RSdata_o, EX_RTdata_o, EX_Imm_o;
  logic [4:0]  EX_RSaddr_o, EX_RTaddr_o, EX_RDaddr_o;
`ifdef HAZARD_STAT_EN
  logic [CNT_W-1:0] StallCnt_o, FlushCnt_o;
`endif
  id_ex_hazard_reg #(
    .DATA_W(32), .REG_AW(5)
`ifdef HAZARD_STAT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ConMux_i(ConMux_i), .Branch_taken_i(Branch_taken_i), .Jump_i(Jump_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .Imm_i(Imm_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .EX_WB_o(EX_WB_o), .EX_M_o(EX_M_o), .EX_ALUSrc_o(EX_ALUSrc_o), .EX_ALUOp_o(EX_ALUOp_o),
    .EX_RegDst_o(EX_RegDst_o), .EX_RSdata_o(EX_RSdata_o), .EX_RTdata_o(EX_RTdata_o), .EX_Imm_o(EX_Imm_o),
    .EX_RSaddr_o(EX_RSaddr_o), .EX_RTaddr_o(EX_RTaddr_o), .EX_RDaddr_o(EX_RDaddr_o),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
`ifdef HAZARD_STAT_EN
    .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o),
`endif
    .IFFlush_o(IFFlush_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rsa, rta, rda;
    logic        pcw, ifw, fl;
    logic [31:0] sc, fc;
  } exp_t;
  exp_t sb[$];
  exp_t prev;
  int n_cmp = 0, n_err = 0;
  logic [31:0] sc_m = 0, fc_m = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk_i)
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctrl", 32'({EX_WB_o, EX_M_o, EX_ALUSrc_o, EX_ALUOp_o, EX_RegDst_o}), 32'(e.ctrl));
      chk("rsdata", EX_RSdata_o, e.rsd);
      chk("rtdata", EX_RTdata_o, e.rtd);
      chk("imm", EX_Imm_o, e.imm);
      chk("rsaddr", 32'(EX_RSaddr_o), 32'(e.rsa));
      chk("rtaddr", 32'(EX_RTaddr_o), 32'(e.rta));
      chk("rdaddr", 32'(EX_RDaddr_o), 32'(e.rda));
      chk("pcwrite", 32'(PCWrite_o), 32'(e.pcw));
      chk("ifidwrite", 32'(IFIDWrite_o), 32'(e.ifw));
      chk("ifflush", 32'(IFFlush_o), 32'(e.fl));
`ifdef HAZARD_STAT_EN
      chk("stallcnt", 32'(StallCnt_o), e.sc);
      chk("flushcnt", 32'(FlushCnt_o), e.fc);
`endif
    end
  function automatic exp_t zero_exp();
    exp_t z;
    z = '{ctrl: 8'h00, rsd: 0, rtd: 0, imm: 0, rsa: 0, rta: 0, rda: 0, pcw: 1'b1, ifw: 1'b1, fl: 1'b0, sc: 0, fc: 0};
    return z;
  endfunction
  task automatic drive(input logic [7:0] ctrl, input logic br, input logic j, input logic [4:0] rsa,
                       input logic [4:0] rta, input logic [4:0] rda, input logic [31:0] rsd,
                       input logic [7:0] e_ctrl, input logic e_pcw, input logic e_ifw, input logic e_fl);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    ConMux_i = ctrl; Branch_taken_i = br; Jump_i = j;
    RSaddr_i = rsa; RTaddr_i = rta; RDaddr_i = rda;
    RSdata_i = rsd; RTdata_i = rsd + 32'h1000; Imm_i = ~rsd;
    e = prev;
    e.ctrl = e_ctrl; e.pcw = e_pcw; e.ifw = e_ifw; e.fl = e_fl; e.sc = sc_m; e.fc = fc_m;
    sb.push_back(e);
    prev.rsd = rsd; prev.rtd = rsd + 32'h1000; prev.imm = ~rsd;
    prev.rsa = rsa; prev.rta = rta; prev.rda = rda;
    if (!e_pcw && sc_m != CNT_MAX) sc_m++;
    if (e_fl && fc_m != CNT_MAX) fc_m++;
  endtask
  initial begin
    prev = zero_exp();
    #1;
    rst_i = 1'b0;
    ConMux_i = 8'($urandom); Branch_taken_i = 1'b1; Jump_i = 1'b1;
    RSdata_i = $urandom; RTdata_i = $urandom; Imm_i = $urandom;
    RSaddr_i = 5'($urandom); RTaddr_i = 5'($urandom); RDaddr_i = 5'($urandom);
    sb.push_back(zero_exp());
    @(negedge clk_i);
    drive(8'h85, 0, 0,  3,  4, 5, 32'h5,  8'h00, 1, 1, 0);
    drive(8'hE8, 0, 0,  1,  2, 0, 32'hA,  8'h85, 1, 1, 0);
    drive(8'h85, 0, 0,  2,  6, 7, 32'h11, 8'hE8, 0, 0, 0);
    drive(8'h85, 0, 0,  2,  6, 7, 32'h11, 8'h00, 1, 1, 0);
    drive(8'hE8, 0, 0,  7,  0, 0, 32'h22, 8'h85, 1, 1, 0);
    drive(8'h85, 0, 0,  0,  0, 3, 32'h33, 8'hE8, 1, 1, 0);
    drive(8'h02, 1, 0,  8,  9, 0, 32'h44, 8'h85, 1, 1, 1);
    drive(8'hE8, 0, 0,  1, 10, 0, 32'h55, 8'h02, 1, 1, 0);
    drive(8'h02, 1, 0, 10, 11, 0, 32'h66, 8'hE8, 0, 0, 0);
    drive(8'h02, 1, 0, 10, 11, 0, 32'h66, 8'h00, 1, 1, 1);
    drive(8'h00, 1, 1,  0,  0, 0, 32'h77, 8'h02, 1, 1, 1);
    drive(8'h18, 0, 0, 12, 13, 0, 32'h88, 8'h00, 1, 1, 0);
    drive(8'hE8, 0, 0,  4, 13, 0, 32'h99, 8'h18, 1, 1, 0);
    drive(8'h85, 0, 0,  5, 13, 2, 32'hAA, 8'hE8, 0, 0, 0);
    @(posedge clk_i);
    #2;
    Branch_taken_i = 1'b1;
    rst_i = 1'b0;
    prev = zero_exp();
    sc_m = 0; fc_m = 0;
    sb.push_back(zero_exp());
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      drive(8'hE8, 0, 0, 0, 2, 0, 32'h100 + i, (i == 0) ? 8'h00 : 8'h85, 1, 1, 0);
      drive(8'h85, 0, 0, 2, 0, 1, 32'h200 + i, 8'hE8, 0, 0, 0);
      drive(8'h85, 0, 0, 2, 0, 1, 32'h200 + i, 8'h00, 1, 1, 0);
    end
    for (int i = 0; i < 4; i++)
      drive(8'h02, 1, 0, 20, 21, 0, 32'h300 + i, (i == 0) ? 8'h85 : 8'h02, 1, 1, 1);
    drive(8'h00, 0, 0, 0, 0, 0, 32'h0, 8'h02, 1, 1, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk_i);
      #1;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
